// File: rtl/map_access_arbiter.sv
// rtl/map_access_arbiter.sv - tile-map RAM arbiter: display reads vs two game-logic writers
//
// Purpose: shares one map RAM port between the display pipeline and two
// game-logic write requesters. Writes are only granted inside the window
// between EOF and the following SOF, never while the display is reading.
// Competing writers are served round-robin. Each grant takes an ARB cycle
// followed by a WRITE cycle, so at most one write lands every two cycles.
//
// Optional feature macro: MAP_ARB_STATS_EN
//   defined   : wr_count counts ram_we cycles per frame (saturates at 255,
//               cleared on EOF; EOF together with a write loads 1)
//   undefined : wr_count is tied to 0 and no counter is built
//
// Ports:
//   clock_50      in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   SOF, EOF      in   start/end-of-frame pulses
//   vid_rd        in   display reads the map this cycle
//   vid_addr      in   display read address (AW)
//   req0, req1    in   write requests, held until ack
//   addr0, addr1  in   write addresses (AW)
//   data0, data1  in   write data (DW)
//   ack0, ack1    out  one-cycle write-done pulses
//   ram_we        out  map RAM write enable
//   ram_addr      out  map RAM address (AW)
//   ram_wdata     out  map RAM write data (DW)
//   wr_count      out  writes this frame (8)
//   vid_conflict  out  sticky: display read during a write

module map_access_arbiter #(
   parameter int AW = 8,
   parameter int DW = 4
) (
   input  logic          clock_50,
   input  logic          reset_n,
   input  logic          SOF,
   input  logic          EOF,
   input  logic          vid_rd,
   input  logic [AW-1:0] vid_addr,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] data0,
   input  logic [DW-1:0] data1,
   output logic          ack0,
   output logic          ack1,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic [7:0]    wr_count,
   output logic          vid_conflict
);

   typedef enum logic [1:0] {
      S_CLOSED = 2'd0,
      S_ARB    = 2'd1,
      S_WRITE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_window;
   logic   r_ptr;
   logic   r_sel;
   logic   r_conflict;
   logic   w_pick;
   logic   w_grant;

   // Both requesting: the pointer decides; otherwise whichever one is asking.
   assign w_pick  = (req0 && req1) ? r_ptr : req1;
   assign w_grant = (r_state == S_ARB) && (w_next == S_WRITE);

   // SOF has priority so a coincident SOF+EOF leaves the window closed.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_window <= 1'b0;
      end else if (SOF) begin
         r_window <= 1'b0;
      end else if (EOF) begin
         r_window <= 1'b1;
      end
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_CLOSED;
      end else begin
         r_state <= w_next;
      end
   end

   // WRITE always exits after one cycle, so a SOF arriving mid-write
   // cannot cut it short; it only stops the next grant.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CLOSED: if (r_window) w_next = S_ARB;
         S_ARB: begin
            if (!r_window) begin
               w_next = S_CLOSED;
            end else if (!vid_rd && (req0 || req1)) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE:  w_next = r_window ? S_ARB : S_CLOSED;
         default:  w_next = S_CLOSED;
      endcase
   end

   // Outputs decode directly from state, so asserting reset drops ram_we
   // and the acks immediately.
   always_comb begin
      ram_we    = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      ram_addr  = vid_addr;
      ram_wdata = '0;
      if (r_state == S_WRITE) begin
         ram_we    = 1'b1;
         ack0      = ~r_sel;
         ack1      = r_sel;
         ram_addr  = r_sel ? addr1 : addr0;
         ram_wdata = r_sel ? data1 : data0;
      end
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_sel <= 1'b0;
         r_ptr <= 1'b0;
      end else begin
         if (w_grant) begin
            r_sel <= w_pick;
         end
         if (r_state == S_WRITE) begin
            r_ptr <= ~r_sel;
         end
      end
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_conflict <= 1'b0;
      end else if (ram_we && vid_rd) begin
         r_conflict <= 1'b1;
      end
   end

   assign vid_conflict = r_conflict;

`ifdef MAP_ARB_STATS_EN
   logic [7:0] r_wr_count;

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_count <= 8'd0;
      end else if (EOF) begin
         r_wr_count <= {7'd0, ram_we};
      end else if (ram_we && (r_wr_count != 8'hFF)) begin
         r_wr_count <= r_wr_count + 8'd1;
      end
   end

   assign wr_count = r_wr_count;
`else
   assign wr_count = 8'd0;
`endif

endmodule

// File: tb/tb_map_access_arbiter.sv
// tb/tb_map_access_arbiter.sv - self-checking bench for map_access_arbiter
module tb_map_access_arbiter;

   localparam int AW = 8;
   localparam int DW = 4;

   logic          clock_50 = 1'b0;
   logic          reset_n;
   logic          SOF, EOF, vid_rd;
   logic [AW-1:0] vid_addr;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] data0, data1;
   logic          ack0, ack1, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [7:0]    wr_count;
   logic          vid_conflict;

   always #5 clock_50 = ~clock_50;

   map_access_arbiter #(.AW(AW), .DW(DW)) dut (
      .clock_50(clock_50), .reset_n(reset_n), .SOF(SOF), .EOF(EOF),
      .vid_rd(vid_rd), .vid_addr(vid_addr),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .wr_count(wr_count), .vid_conflict(vid_conflict)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: a grant happens on a cycle where the arbiter is
   // eligible (window was open last cycle and no grant was made last cycle),
   // the window is open, the display is idle and someone is requesting.
   // The write lands on the following cycle.
   bit m_window, m_elig, m_wr, m_wsel, m_ptr, m_conf;
   int m_cnt;
   bit e_ack0, e_ack1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_window = 0; m_elig = 0; m_wr = 0; m_wsel = 0; m_ptr = 0; m_conf = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit grant, choose;
      grant  = m_elig && m_window && !vid_rd && (req0 || req1);
      choose = (req0 && req1) ? m_ptr : req1;
      if (m_wr) begin
         m_ptr = !m_wsel;
         if (vid_rd) m_conf = 1;
      end
      if (EOF) m_cnt = m_wr ? 1 : 0;
      else if (m_wr && m_cnt < 255) m_cnt = m_cnt + 1;
      m_elig = m_window && !grant;
      m_wr   = grant;
      if (grant) m_wsel = choose;
      m_window = SOF ? 1'b0 : (EOF ? 1'b1 : m_window);
   endtask

   // Called just after a falling edge with this cycle's inputs applied.
   task automatic tick();
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      int            exp_cnt;
      #1;
      e_ack0   = m_wr && !m_wsel;
      e_ack1   = m_wr && m_wsel;
      exp_addr = m_wr ? (m_wsel ? addr1 : addr0) : vid_addr;
      exp_data = m_wr ? (m_wsel ? data1 : data0) : '0;
`ifdef MAP_ARB_STATS_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 0;
`endif
      chk("ram_we", ram_we, m_wr);
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_wdata", ram_wdata, exp_data);
      chk("vid_conflict", vid_conflict, m_conf);
      chk("wr_count", wr_count, exp_cnt);
      if (reset_n) model_step();
      else model_reset();
      @(negedge clock_50);
   endtask

   task automatic clear_inputs();
      SOF = 0; EOF = 0; vid_rd = 0; vid_addr = 8'h00;
      req0 = 0; req1 = 0; addr0 = 8'h00; addr1 = 8'h00; data0 = 4'h0; data1 = 4'h0;
   endtask

   task automatic do_reset();
      reset_n = 0;
      clear_inputs();
      model_reset();
      tick();
      tick();
      reset_n = 1;
   endtask

   initial begin
      reset_n = 0;
      clear_inputs();
      model_reset();
      @(negedge clock_50);

      // Reset state
      #1;
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_conflict", vid_conflict, 0);
      tick();
      reset_n = 1;

      // No EOF since reset: no grant, RAM address follows the display
      req1 = 1; addr1 = 8'hA5; data1 = 4'h9;
      for (int i = 0; i < 6; i++) begin
         vid_addr = AW'($urandom);
         #1;
         chk("noeof_ack1", ack1, 0);
         chk("noeof_addr", ram_addr, vid_addr);
         tick();
      end

      // Single write: grant two cycles after the window opens
      do_reset();
      EOF = 1;
      tick();
      EOF = 0; req0 = 1; addr0 = 8'h12; data0 = 4'h5;
      tick();
      tick();
      #1;
      chk("w1_ram_we", ram_we, 1);
      chk("w1_ack0", ack0, 1);
      chk("w1_addr", ram_addr, 8'h12);
      chk("w1_data", ram_wdata, 4'h5);
      tick();
      req0 = 0;
      tick();

      // Both held: grants alternate 0,1,0,1 every second cycle
      do_reset();
      EOF = 1; req0 = 1; req1 = 1;
      addr0 = 8'h40; data0 = 4'h3; addr1 = 8'h81; data1 = 4'hE;
      tick();
      EOF = 0;
      tick();
      for (int k = 2; k < 10; k++) begin
         #1;
         chk("rr_we", ram_we, k % 2);
         chk("rr_ack0", ack0, (k % 4) == 3);
         chk("rr_ack1", ack1, (k % 4) == 1);
         tick();
      end
      req0 = 0; req1 = 0;
      tick();

      // Display busy: no grant; read during WRITE flags a conflict
      do_reset();
      EOF = 1;
      tick();
      EOF = 0; req0 = 1; addr0 = 8'h33; data0 = 4'hC; vid_rd = 1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("vbusy_we", ram_we, 0);
         chk("vbusy_ack0", ack0, 0);
         tick();
      end
      vid_rd = 0;
      tick();
      vid_rd = 1;
      #1;
      chk("vconf_we", ram_we, 1);
      chk("vconf_ack0", ack0, 1);
      tick();
      req0 = 0;
      #1;
      chk("vconf_flag", vid_conflict, 1);
      tick();
      vid_rd = 0;
      tick();
      #1;
      chk("vconf_sticky", vid_conflict, 1);
      tick();

      // SOF during WRITE: write completes, then nothing more
      do_reset();
      EOF = 1;
      tick();
      EOF = 0; req0 = 1; addr0 = 8'h5A; data0 = 4'h7;
      tick();
      tick();
      SOF = 1;
      #1;
      chk("sof_we", ram_we, 1);
      chk("sof_ack0", ack0, 1);
      tick();
      SOF = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("sof_closed", ram_we, 0);
         tick();
      end
      SOF = 1; EOF = 1;
      tick();
      SOF = 0; EOF = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("sofeof_closed", ram_we, 0);
         tick();
      end
      req0 = 0;
      tick();

      // Reset asserted mid-WRITE
      do_reset();
      EOF = 1;
      tick();
      EOF = 0; req0 = 1; addr0 = 8'h77; data0 = 4'h1;
      tick();
      tick();
      #1;
      chk("midrst_pre_we", ram_we, 1);
      reset_n = 0;
      #1;
      chk("midrst_we", ram_we, 0);
      chk("midrst_ack0", ack0, 0);
      model_reset();
      req0 = 0;
      tick();
      reset_n = 1;
      tick();
      tick();

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         SOF      = ($urandom_range(0, 39) == 0);
         EOF      = ($urandom_range(0, 29) == 0);
         vid_rd   = ($urandom_range(0, 3) == 0);
         vid_addr = AW'($urandom);
         tick();
         if ((req0 && e_ack0) || (!req0 && $urandom_range(0, 2) == 0)) begin
            req0  = $urandom_range(0, 1);
            addr0 = AW'($urandom);
            data0 = DW'($urandom);
         end
         if ((req1 && e_ack1) || (!req1 && $urandom_range(0, 2) == 0)) begin
            req1  = $urandom_range(0, 1);
            addr1 = AW'($urandom);
            data1 = DW'($urandom);
         end
      end

`ifdef MAP_ARB_STATS_EN
      // More than 255 writes in one window saturate the counter
      do_reset();
      EOF = 1;
      tick();
      EOF = 0; req0 = 1; addr0 = 8'h01; data0 = 4'h2;
      for (int i = 0; i < 620; i++) tick();
      #1;
      chk("stats_sat", wr_count, 255);
      req0 = 0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/map_access_arbiter.md
MAP_ACCESS_ARBITER -- requirements
Module: map_access_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning tile-map address width (one map cell per address).
REQ-002 SHALL have parameter DW, default 4, meaning tile-code width.
REQ-003 SHALL have port clock_50  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port SOF  input  1  start-of-frame pulse from the video timing generator.
REQ-006 SHALL have port EOF  input  1  end-of-frame pulse from the video timing generator.
REQ-007 SHALL have port vid_rd  input  1  display pipeline reads the map this cycle.
REQ-008 SHALL have port vid_addr  input  AW  display read address.
REQ-009 SHALL have ports req0, req1  input  1 each  game-logic write requests (player 0 / player 1).
REQ-010 SHALL have ports addr0, addr1  input  AW each  write address per requester.
REQ-011 SHALL have ports data0, data1  input  DW each  write data per requester.
REQ-012 SHALL have ports ack0, ack1  output  1 each  one-cycle write-done pulse per requester.
REQ-013 SHALL have ports ram_we (output, 1), ram_addr (output, AW) and ram_wdata (output, DW): the map RAM port.
REQ-014 SHALL have ports wr_count (output, 8), frame writes, and vid_conflict (output, 1), sticky clash flag.

Function
REQ-015 SHALL keep a window flag: set on the cycle after EOF, cleared on the cycle after SOF; when SOF and EOF are high together, SOF wins and the window is cleared.
REQ-016 SHALL implement the FSM states CLOSED, ARB and WRITE; CLOSED goes to ARB when window=1.
REQ-017 In ARB with window=1, vid_rd=0 and any req high, the FSM SHALL pick a requester and go to WRITE; when vid_rd=1 it SHALL stay in ARB.
REQ-018 The pick SHALL be round-robin: with both requests high it takes the requester named by a pointer (reset value 0); with one request high it takes that requester.
REQ-019 In WRITE, ram_we SHALL be 1 for exactly one cycle, with ram_addr/ram_wdata taken from the chosen requester's addr/data and the matching ack pulsed in the same cycle.
REQ-020 On leaving WRITE the pointer SHALL point at the other requester; the FSM goes to ARB if window=1, otherwise to CLOSED.
REQ-021 Requesters SHALL hold req, addr and data stable until ack; throughput is at most one write per 2 cycles.
REQ-022 A WRITE SHALL always complete once entered, even if SOF arrives in that cycle.
REQ-023 When ram_we=0, ram_addr SHALL equal vid_addr and ram_wdata SHALL be 0; the write/read mux is combinational on FSM state.
REQ-024 If vid_rd=1 during WRITE, the write SHALL proceed and vid_conflict SHALL be set; only reset clears vid_conflict.
REQ-025 In ARB with window=0, the FSM SHALL return to CLOSED without granting.

Reset
REQ-026 While reset_n=0, the block SHALL force FSM=CLOSED, window=0, pointer=0, ack0=ack1=0, ram_we=0, wr_count=0 and vid_conflict=0 asynchronously; an in-flight WRITE SHALL be aborted with no ack.
REQ-027 After reset release, the first grant SHALL occur no earlier than the cycle after the first EOF.

Configuration
REQ-028 With MAP_ARB_STATS_EN defined, wr_count SHALL increment on each ram_we cycle, saturate at 255 and clear on EOF; EOF in the same cycle as a write loads 1.
REQ-029 Without MAP_ARB_STATS_EN, wr_count SHALL be constant 0 and no counter logic SHALL be built; all other behaviour is identical.

Verification
REQ-030 EOF pulse, then req0=1 (addr0=8'h12, data0=4'h5): ack0 and ram_we exactly 2 cycles after window opens; ram_addr=8'h12, ram_wdata=4'h5.
REQ-031 req0 and req1 held through a window: grants alternate 0,1,0,1, one ram_we every 2 cycles.
REQ-032 req1 high with no EOF since reset: no ack1, and ram_addr tracks vid_addr.
REQ-033 vid_rd held high during the window: no grant; when vid_rd is forced high in WRITE, the write completes and vid_conflict=1.
REQ-034 SOF in the cycle of WRITE: that write acks and no further grant follows; SOF+EOF together leave the window closed.
REQ-035 reset_n low mid-WRITE: ram_we=0 immediately, no ack; with MAP_ARB_STATS_EN, 300 writes in one window give wr_count=255.
